// File: rtl/ad_ip_jesd204_tpl_dac_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ad_ip_jesd204_tpl_dac_pkg : source-select codes and pattern player states   |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
package ad_ip_jesd204_tpl_dac_pkg;

  localparam logic [3:0] SEL_DDS      = 4'd0;
  localparam logic [3:0] SEL_PAT      = 4'd1;
  localparam logic [3:0] SEL_DMA      = 4'd2;
  localparam logic [3:0] SEL_ZERO     = 4'd3;
  localparam logic [3:0] SEL_PN7_INV  = 4'd4;
  localparam logic [3:0] SEL_PN15_INV = 4'd5;
  localparam logic [3:0] SEL_PN7      = 4'd6;
  localparam logic [3:0] SEL_PN15     = 4'd7;
  localparam logic [3:0] SEL_RAMP     = 4'd8;
  localparam logic [3:0] SEL_PAT_RAM  = 4'd9;

  typedef enum logic [1:0] {
    PAT_IDLE  = 2'd0,
    PAT_ARMED = 2'd1,
    PAT_PLAY  = 2'd2,
    PAT_DONE  = 2'd3
  } pat_state_t;

endpackage
`default_nettype wire

// File: rtl/ad_ip_jesd204_tpl_dac_pat_player.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ad_ip_jesd204_tpl_dac_pat_player : pattern memory with one-shot/loop player |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module ad_ip_jesd204_tpl_dac_pat_player
  import ad_ip_jesd204_tpl_dac_pkg::*;
#(
  parameter int DATA_PATH_WIDTH      = 4,
  parameter int CONVERTER_RESOLUTION = 16,
  parameter int PAT_DEPTH            = 64
) (
  input  logic                                             clk,
  input  logic                                             reset,
  input  logic                                             active,
  input  logic                                             sync,
  input  logic                                             pat_wr,
  input  logic [$clog2(PAT_DEPTH)-1:0]                     pat_waddr,
  input  logic [CONVERTER_RESOLUTION-1:0]                  pat_wdata,
  input  logic [$clog2(PAT_DEPTH/DATA_PATH_WIDTH):0]       pat_length,
  input  logic                                             pat_loop,
  output logic [DATA_PATH_WIDTH*CONVERTER_RESOLUTION-1:0]  beat_data,
  output logic                                             pat_busy,
  output logic                                             pat_done
);

  localparam int CR    = CONVERTER_RESOLUTION;
  localparam int BEATS = PAT_DEPTH / DATA_PATH_WIDTH;
  localparam int AW    = $clog2(PAT_DEPTH);
  localparam int LEN_W = $clog2(BEATS) + 1;
  localparam int PTR_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [LEN_W-1:0] C_BEATS = LEN_W'(BEATS);

  logic [CR-1:0]    r_mem [PAT_DEPTH];
  pat_state_t       r_state;
  pat_state_t       w_state_nxt;
  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W-1:0] w_ptr_nxt;
  logic             r_done;
  logic             w_done_nxt;
  logic [LEN_W-1:0] w_len;
  logic             w_last;

  always_ff @(posedge clk) begin
    if (pat_wr) begin
      r_mem[pat_waddr] <= pat_wdata;
    end
  end

  // Zero or oversize length means "whole memory".
  assign w_len  = (pat_length == '0 || pat_length > C_BEATS) ? C_BEATS : pat_length;
  assign w_last = (LEN_W'(r_ptr) + LEN_W'(1)) >= w_len;

  generate
    for (genvar i = 0; i < DATA_PATH_WIDTH; i++) begin : g_lane
      logic [AW-1:0] w_raddr;
      assign w_raddr = AW'(r_ptr) * AW'(DATA_PATH_WIDTH) + AW'(i);
      assign beat_data[i*CR +: CR] = (r_state == PAT_PLAY) ? r_mem[w_raddr] : '0;
    end
  endgenerate

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_done_nxt  = 1'b0;
    if (!active) begin
      w_state_nxt = PAT_IDLE;
      w_ptr_nxt   = '0;
    end else begin
      case (r_state)
        PAT_IDLE: begin
          w_state_nxt = PAT_ARMED;
        end
        PAT_ARMED, PAT_DONE: begin
          if (sync) begin
            w_state_nxt = PAT_PLAY;
            w_ptr_nxt   = '0;
          end
        end
        PAT_PLAY: begin
          if (sync) begin
            w_ptr_nxt = '0;
          end else if (w_last) begin
            if (pat_loop) begin
              w_ptr_nxt = '0;
            end else begin
              w_state_nxt = PAT_DONE;
              w_done_nxt  = 1'b1;
            end
          end else begin
            w_ptr_nxt = r_ptr + PTR_W'(1);
          end
        end
        default: begin
          w_state_nxt = PAT_IDLE;
          w_ptr_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= PAT_IDLE;
      r_ptr   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign pat_busy = (r_state == PAT_PLAY);
  assign pat_done = r_done;

endmodule
`default_nettype wire

// File: rtl/ad_ip_jesd204_tpl_dac_channel_ext.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ad_ip_jesd204_tpl_dac_channel_ext : per-channel DAC sample source selector  |
// | Optional ramp generator built when AD_TPL_DAC_RAMP_EN is defined. Rev 1.0   |
// +----------------------------------------------------------------------------+
module ad_ip_jesd204_tpl_dac_channel_ext
  import ad_ip_jesd204_tpl_dac_pkg::*;
#(
  parameter int DATA_PATH_WIDTH      = 4,
  parameter int CONVERTER_RESOLUTION = 16,
  parameter int BITS_PER_SAMPLE      = 16,
  parameter int PAT_DEPTH            = 64
) (
  input  logic                                            clk,
  input  logic                                            reset,
  input  logic [DATA_PATH_WIDTH*BITS_PER_SAMPLE-1:0]      dma_data,
  input  logic [DATA_PATH_WIDTH*CONVERTER_RESOLUTION-1:0] dds_data,
  input  logic [DATA_PATH_WIDTH*CONVERTER_RESOLUTION-1:0] pn7_data,
  input  logic [DATA_PATH_WIDTH*CONVERTER_RESOLUTION-1:0] pn15_data,
  input  logic                                            dac_data_sync,
  input  logic [3:0]                                      dac_data_sel,
  input  logic                                            dac_mask_enable,
  input  logic [15:0]                                     dac_pat_data_0,
  input  logic [15:0]                                     dac_pat_data_1,
  input  logic [15:0]                                     dac_ramp_start,
  input  logic [15:0]                                     dac_ramp_step,
  input  logic                                            pat_wr,
  input  logic [$clog2(PAT_DEPTH)-1:0]                    pat_waddr,
  input  logic [CONVERTER_RESOLUTION-1:0]                 pat_wdata,
  input  logic [$clog2(PAT_DEPTH/DATA_PATH_WIDTH):0]      pat_length,
  input  logic                                            pat_loop,
  output logic [DATA_PATH_WIDTH*CONVERTER_RESOLUTION-1:0] dac_data,
  output logic                                            dac_enable,
  output logic                                            pat_busy,
  output logic                                            pat_done
);

  localparam int CR = CONVERTER_RESOLUTION;
  localparam int DW = DATA_PATH_WIDTH * CR;

  logic [3:0]    w_src;
  logic [DW-1:0] w_dma;
  logic [DW-1:0] w_fixed;
  logic [DW-1:0] w_ramp;
  logic [DW-1:0] w_beat;
  logic [DW-1:0] w_mux;
  logic [DW-1:0] r_data;
  logic          r_enable;

  always_comb begin
    w_src = dac_data_sel;
    if (dac_mask_enable) begin
      w_src = SEL_DMA;
    end else if (dac_data_sel > SEL_PAT_RAM) begin
      w_src = SEL_DDS;
`ifndef AD_TPL_DAC_RAMP_EN
    end else if (dac_data_sel == SEL_RAMP) begin
      w_src = SEL_DDS;
`endif
    end
  end

  generate
    for (genvar i = 0; i < DATA_PATH_WIDTH; i++) begin : g_dma_lane
      assign w_dma[i*CR +: CR] = dma_data[BITS_PER_SAMPLE*i +: CR];
    end

    if (DATA_PATH_WIDTH > 1) begin : g_fixed_multi
      for (genvar i = 0; i < DATA_PATH_WIDTH; i++) begin : g_lane
        assign w_fixed[i*CR +: CR] = (i % 2 == 0) ? dac_pat_data_0[CR-1:0]
                                                  : dac_pat_data_1[CR-1:0];
      end
    end else begin : g_fixed_single
      // Single-lane paths alternate words in time; sync realigns to word 0.
      logic r_phase;
      logic w_phase;
      assign w_phase = dac_data_sync ? 1'b0 : r_phase;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_phase <= 1'b0;
        end else begin
          r_phase <= ~w_phase;
        end
      end
      assign w_fixed = w_phase ? dac_pat_data_1[CR-1:0] : dac_pat_data_0[CR-1:0];
    end
  endgenerate

`ifdef AD_TPL_DAC_RAMP_EN
  logic [CR-1:0] r_base;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_base <= '0;
    end else if (dac_data_sync) begin
      r_base <= dac_ramp_start[CR-1:0];
    end else begin
      r_base <= r_base + CR'(DATA_PATH_WIDTH) * dac_ramp_step[CR-1:0];
    end
  end

  generate
    for (genvar i = 0; i < DATA_PATH_WIDTH; i++) begin : g_ramp_lane
      assign w_ramp[i*CR +: CR] = r_base + CR'(i) * dac_ramp_step[CR-1:0];
    end
  endgenerate
`else
  logic w_ramp_unused;
  assign w_ramp_unused = ^{dac_ramp_start, dac_ramp_step};
  assign w_ramp        = '0;
`endif

  ad_ip_jesd204_tpl_dac_pat_player #(
    .DATA_PATH_WIDTH      (DATA_PATH_WIDTH),
    .CONVERTER_RESOLUTION (CONVERTER_RESOLUTION),
    .PAT_DEPTH            (PAT_DEPTH)
  ) i_pat_player (
    .clk        (clk),
    .reset      (reset),
    .active     (w_src == SEL_PAT_RAM),
    .sync       (dac_data_sync),
    .pat_wr     (pat_wr),
    .pat_waddr  (pat_waddr),
    .pat_wdata  (pat_wdata),
    .pat_length (pat_length),
    .pat_loop   (pat_loop),
    .beat_data  (w_beat),
    .pat_busy   (pat_busy),
    .pat_done   (pat_done)
  );

  always_comb begin
    w_mux = dds_data;
    case (w_src)
      SEL_DDS:      w_mux = dds_data;
      SEL_PAT:      w_mux = w_fixed;
      SEL_DMA:      w_mux = w_dma;
      SEL_ZERO:     w_mux = '0;
      SEL_PN7_INV:  w_mux = ~pn7_data;
      SEL_PN15_INV: w_mux = ~pn15_data;
      SEL_PN7:      w_mux = pn7_data;
      SEL_PN15:     w_mux = pn15_data;
      SEL_RAMP:     w_mux = w_ramp;
      SEL_PAT_RAM:  w_mux = w_beat;
      default:      w_mux = dds_data;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data   <= '0;
      r_enable <= 1'b0;
    end else begin
      r_data   <= w_mux;
      r_enable <= (w_src == SEL_DMA);
    end
  end

  assign dac_data   = r_data;
  assign dac_enable = r_enable;

endmodule
`default_nettype wire

// File: tb/tb_ad_ip_jesd204_tpl_dac_channel_ext.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_ad_ip_jesd204_tpl_dac_channel_ext : self-checking bench for the channel  |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_ad_ip_jesd204_tpl_dac_channel_ext;

  localparam int DPW   = 4;
  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] dma_data = '0;
  logic [63:0] dds_data = '0;
  logic [63:0] pn7_data = '0;
  logic [63:0] pn15_data = '0;
  logic        dac_data_sync = 1'b0;
  logic [3:0]  dac_data_sel = '0;
  logic        dac_mask_enable = 1'b0;
  logic [15:0] dac_pat_data_0 = '0;
  logic [15:0] dac_pat_data_1 = '0;
  logic [15:0] dac_ramp_start = '0;
  logic [15:0] dac_ramp_step = '0;
  logic        pat_wr = 1'b0;
  logic [5:0]  pat_waddr = '0;
  logic [15:0] pat_wdata = '0;
  logic [4:0]  pat_length = '0;
  logic        pat_loop = 1'b0;
  logic [63:0] dac_data;
  logic        dac_enable;
  logic        pat_busy;
  logic        pat_done;

  int checks = 0;
  int errors = 0;
  bit rnd_dma = 1'b0;

  ad_ip_jesd204_tpl_dac_channel_ext #(
    .DATA_PATH_WIDTH(4), .CONVERTER_RESOLUTION(16), .BITS_PER_SAMPLE(16), .PAT_DEPTH(64)
  ) dut (
    .clk(clk), .reset(reset), .dma_data(dma_data), .dds_data(dds_data),
    .pn7_data(pn7_data), .pn15_data(pn15_data), .dac_data_sync(dac_data_sync),
    .dac_data_sel(dac_data_sel), .dac_mask_enable(dac_mask_enable),
    .dac_pat_data_0(dac_pat_data_0), .dac_pat_data_1(dac_pat_data_1),
    .dac_ramp_start(dac_ramp_start), .dac_ramp_step(dac_ramp_step),
    .pat_wr(pat_wr), .pat_waddr(pat_waddr), .pat_wdata(pat_wdata),
    .pat_length(pat_length), .pat_loop(pat_loop), .dac_data(dac_data),
    .dac_enable(dac_enable), .pat_busy(pat_busy), .pat_done(pat_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int eff_src(input logic mask, input logic [3:0] sel);
    if (mask) return 2;
    if (sel > 4'd9) return 0;
`ifndef AD_TPL_DAC_RAMP_EN
    if (sel == 4'd8) return 0;
`endif
    return int'(sel);
  endfunction

  // Reference model: what the outputs must show after each rising edge.
  logic [15:0] m_mem [DEPTH];
  bit          m_play = 1'b0;
  bit          m_wait = 1'b0;
  int          m_beat = 0;
  logic [15:0] m_base = '0;
  logic [63:0] e_data;
  bit          e_en, e_busy, e_done;

  always @(posedge clk) begin : p_model
    int          s;
    int          len;
    logic [63:0] beat;
    s = eff_src(dac_mask_enable, dac_data_sel);
    if (reset) begin
      e_data = '0; e_en = 1'b0; e_busy = 1'b0; e_done = 1'b0;
      m_play = 1'b0; m_wait = 1'b0; m_beat = 0; m_base = '0;
    end else begin
      for (int i = 0; i < DPW; i++)
        beat[16*i +: 16] = m_play ? m_mem[m_beat*DPW + i] : 16'h0;
      case (s)
        0: e_data = dds_data;
        1: e_data = {dac_pat_data_1, dac_pat_data_0, dac_pat_data_1, dac_pat_data_0};
        2: e_data = dma_data;
        3: e_data = '0;
        4: e_data = ~pn7_data;
        5: e_data = ~pn15_data;
        6: e_data = pn7_data;
        7: e_data = pn15_data;
        8: for (int i = 0; i < DPW; i++) e_data[16*i +: 16] = 16'(m_base + i*dac_ramp_step);
        default: e_data = beat;
      endcase
      e_en   = (s == 2);
      e_done = 1'b0;
      len = (pat_length == 0 || pat_length > 16) ? 16 : int'(pat_length);
      if (s != 9) begin
        m_play = 1'b0; m_wait = 1'b0; m_beat = 0;
      end else if (m_play) begin
        if (dac_data_sync) m_beat = 0;
        else if (m_beat >= len - 1) begin
          if (pat_loop) m_beat = 0;
          else begin m_play = 1'b0; m_wait = 1'b1; e_done = 1'b1; end
        end else m_beat++;
      end else if (m_wait) begin
        if (dac_data_sync) begin m_play = 1'b1; m_wait = 1'b0; m_beat = 0; end
      end else begin
        m_wait = 1'b1;
      end
      e_busy = m_play;
      m_base = dac_data_sync ? dac_ramp_start : 16'(m_base + 4*dac_ramp_step);
    end
    if (pat_wr) m_mem[pat_waddr] = pat_wdata;
    #1;
    check("model_data", dac_data, e_data);
    check("model_enable", 64'(dac_enable), 64'(e_en));
    check("model_busy", 64'(pat_busy), 64'(e_busy));
    check("model_done", 64'(pat_done), 64'(e_done));
  end

  task automatic cyc();
    @(posedge clk);
    #2;
    dds_data  = {$urandom, $urandom};
    pn7_data  = {$urandom, $urandom};
    pn15_data = {$urandom, $urandom};
    if (rnd_dma) dma_data = {$urandom, $urandom};
  endtask

  localparam logic [63:0] C_BEAT0 = 64'h0003_0002_0001_0000;
  localparam logic [63:0] C_BEAT1 = 64'h0007_0006_0005_0004;

  initial begin : p_main
    logic [63:0] exp_v;
    cyc(); cyc();
    check("reset_data", dac_data, 64'h0);
    check("reset_enable", 64'(dac_enable), 64'h0);
    check("reset_busy", 64'(pat_busy), 64'h0);
    check("reset_done", 64'(pat_done), 64'h0);
    reset = 1'b0;

    dma_data = 64'hDEF0_9ABC_5678_1234; dac_data_sel = 4'd2; cyc();
    check("dma_data", dac_data, 64'hDEF0_9ABC_5678_1234);
    check("dma_enable", 64'(dac_enable), 64'h1);

    dac_pat_data_0 = 16'h1111; dac_pat_data_1 = 16'h2222; dac_data_sel = 4'd1; cyc();
    check("fixed_pattern", dac_data, 64'h2222_1111_2222_1111);
    check("fixed_enable", 64'(dac_enable), 64'h0);
    dac_mask_enable = 1'b1; cyc();
    check("mask_data", dac_data, 64'hDEF0_9ABC_5678_1234);
    check("mask_enable", 64'(dac_enable), 64'h1);
    dac_mask_enable = 1'b0; dac_data_sel = 4'd0;

    for (int a = 0; a < DEPTH; a++) begin
      pat_wr = 1'b1; pat_waddr = 6'(a); pat_wdata = 16'(a); cyc();
    end
    pat_wr = 1'b0;

    pat_length = 5'd2; pat_loop = 1'b0; dac_data_sel = 4'd9; cyc(); cyc();
    check("armed_data", dac_data, 64'h0);
    dac_data_sync = 1'b1; cyc(); dac_data_sync = 1'b0;
    check("play_busy", 64'(pat_busy), 64'h1);
    cyc();
    check("oneshot_beat0", dac_data, C_BEAT0);
    check("oneshot_beat0_done", 64'(pat_done), 64'h0);
    cyc();
    check("oneshot_beat1", dac_data, C_BEAT1);
    check("oneshot_done_pulse", 64'(pat_done), 64'h1);
    cyc();
    check("after_done_data", dac_data, 64'h0);
    check("after_done_pulse", 64'(pat_done), 64'h0);
    repeat (3) cyc();
    check("done_hold_busy", 64'(pat_busy), 64'h0);

    pat_loop = 1'b1; dac_data_sync = 1'b1; cyc(); dac_data_sync = 1'b0;
    cyc(); check("loop_beat0", dac_data, C_BEAT0);
    cyc(); check("loop_beat1", dac_data, C_BEAT1);
    cyc(); check("loop_beat0_again", dac_data, C_BEAT0);
    dac_data_sync = 1'b1; cyc(); dac_data_sync = 1'b0;
    check("sync_mid_beat1", dac_data, C_BEAT1);
    cyc(); check("resync_beat0", dac_data, C_BEAT0);
    exp_v = dds_data; dac_data_sel = 4'd0; cyc();
    check("idle_dds", dac_data, exp_v);
    check("idle_busy", 64'(pat_busy), 64'h0);

`ifdef AD_TPL_DAC_RAMP_EN
    dac_ramp_start = 16'hFFFE; dac_ramp_step = 16'h0001; dac_data_sel = 4'd8;
    dac_data_sync = 1'b1; cyc(); dac_data_sync = 1'b0;
    cyc(); check("ramp_wrap", dac_data, 64'h0001_0000_FFFF_FFFE);
    cyc(); check("ramp_next", dac_data, 64'h0005_0004_0003_0002);
`else
    exp_v = dds_data; dac_data_sel = 4'd8; cyc();
    check("sel8_is_dds", dac_data, exp_v);
`endif

    dac_data_sel = 4'd9; pat_length = 5'd2; pat_loop = 1'b1; cyc(); cyc();
    dac_data_sync = 1'b1; cyc(); dac_data_sync = 1'b0; cyc(); cyc();
    check("pre_reset_busy", 64'(pat_busy), 64'h1);
    #1 reset = 1'b1;
    #1;
    check("async_reset_data", dac_data, 64'h0);
    check("async_reset_busy", 64'(pat_busy), 64'h0);
    cyc(); cyc(); reset = 1'b0;
    cyc(); dac_data_sync = 1'b1; cyc(); dac_data_sync = 1'b0;
    cyc(); check("replay_beat0", dac_data, C_BEAT0);
    cyc(); check("replay_beat1", dac_data, C_BEAT1);

    rnd_dma = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 15) == 0)
        dac_data_sel = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'd9;
      dac_mask_enable = ($urandom_range(0, 40) == 0);
      dac_data_sync   = ($urandom_range(0, 19) == 0);
      pat_wr    = ($urandom_range(0, 3) == 0);
      pat_waddr = 6'($urandom);
      pat_wdata = 16'($urandom);
      if ($urandom_range(0, 31) == 0) pat_length = 5'($urandom);
      if ($urandom_range(0, 63) == 0) pat_loop = ~pat_loop;
      if ($urandom_range(0, 31) == 0) begin
        dac_pat_data_0 = 16'($urandom); dac_pat_data_1 = 16'($urandom);
        dac_ramp_start = 16'($urandom); dac_ramp_step  = 16'($urandom);
      end
      cyc();
    end
    pat_wr = 1'b0; dac_data_sync = 1'b0;
    cyc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ad_ip_jesd204_tpl_dac_channel_ext.md
# ad_ip_jesd204_tpl_dac_channel_ext

Per-channel DAC sample source selector for the JESD204 transport layer. It is the generalised successor of the existing TPL DAC channel. On top of the DMA, DDS, PN and fixed-pattern sources it adds a writable pattern memory with one-shot and loop playback, sync-aligned triggering, and an optional ramp generator. One instance sits per converter channel, between the DMA/DDS/PN generators and the TPL framer.

## Interface
- DATA_PATH_WIDTH, 4: samples per clock per channel.
- CONVERTER_RESOLUTION (CR), 16: output sample width.
- BITS_PER_SAMPLE, 16: DMA sample container width; data is LSB aligned.
- PAT_DEPTH, 64: pattern memory depth in samples; power of 2, multiple of DATA_PATH_WIDTH.
- clk  in  1  channel clock; all logic is in this single domain.
- reset  in  1  asynchronous, active-high reset.
- dma_data  in  DATA_PATH_WIDTH*BITS_PER_SAMPLE  DMA samples.
- dds_data  in  DATA_PATH_WIDTH*CR  DDS samples.
- pn7_data, pn15_data  in  DATA_PATH_WIDTH*CR  PN sequences.
- dac_data_sync  in  1  frame-alignment pulse.
- dac_data_sel  in  4  source select.
- dac_mask_enable  in  1  forces the DMA source.
- dac_pat_data_0, dac_pat_data_1  in  16  fixed two-word pattern; low CR bits used.
- dac_ramp_start, dac_ramp_step  in  16  ramp seed and increment; low CR bits used.
- pat_wr  in  1  pattern memory write strobe.
- pat_waddr  in  $clog2(PAT_DEPTH)  write address, in samples.
- pat_wdata  in  CR  write data.
- pat_length  in  $clog2(PAT_DEPTH/DATA_PATH_WIDTH)+1  playback length in beats (DATA_PATH_WIDTH samples each).
- pat_loop  in  1  1 = loop playback, 0 = one-shot.
- dac_data  out  DATA_PATH_WIDTH*CR  registered output samples. Lane 0 is in the LSBs.
- dac_enable  out  1  high when the effective source is DMA.
- pat_busy  out  1  high while the player is in PLAY.
- pat_done  out  1  one-cycle pulse when a one-shot playback completes.

## Operation
- Source decode, in priority order:
  - dac_mask_enable=1 → DMA.
  - Otherwise dac_data_sel: 0 DDS, 1 fixed pattern, 2 DMA, 3 zero, 4 ~pn7, 5 ~pn15, 6 pn7, 7 pn15, 8 ramp, 9 pattern player.
  - Values 10–15 → DDS.
- DMA lane i = dma_data[BITS_PER_SAMPLE*i +: CR]; upper bits are dropped.
- Fixed pattern:
  - DATA_PATH_WIDTH>1: lanes alternate pat_0 (even lanes) and pat_1 (odd lanes).
  - DATA_PATH_WIDTH=1: output toggles pat_0/pat_1 each cycle. Sync forces pat_0 on the next cycle.
- Ramp:
  - Lane i = base + i*step (mod 2^CR).
  - On sync, base ← start. Otherwise base ← base + DATA_PATH_WIDTH*step each cycle; wraps naturally.
- Pattern player FSM, states IDLE, ARMED, PLAY, DONE:
  - Any state, effective source ≠ 9 → IDLE, ptr←0.
  - IDLE → ARMED when effective source = 9.
  - ARMED, DONE → PLAY on sync, ptr←0.
  - PLAY:
    - Sync → ptr←0.
    - Else if ptr ≥ len-1: with pat_loop, ptr←0; without pat_loop, → DONE and pat_done pulses.
    - Else ptr←ptr+1.
  - len = pat_length. A value of 0 or a value above PAT_DEPTH/DATA_PATH_WIDTH is treated as PAT_DEPTH/DATA_PATH_WIDTH.
  - In PLAY, lane i = mem[ptr*DATA_PATH_WIDTH+i]. In IDLE, ARMED and DONE the output is zero.
- Memory writes:
  - A write is accepted in any state.
  - A read of the same address in the same cycle returns the old data.
  - Memory is not reset.

## Timing
- Reset values: dac_data=0, dac_enable=0, pat_busy=0, pat_done=0, FSM=IDLE, ptr=0, ramp base=0.
- Latency is 1 clock from any source input, or from a dac_data_sel or mask change, to dac_data and dac_enable.
- Sync sampled at cycle T → PLAY at T+1 → beat 0 on dac_data at T+2.
- pat_done is asserted in the cycle the FSM enters DONE. Beat len-1 appears on dac_data in that same cycle.
- Reset asserted mid-playback: outputs clear immediately, asynchronously. Memory contents are retained.
- A pat_length change during PLAY takes effect at the next pointer compare.

## Configuration
- AD_TPL_DAC_RAMP_EN defined: the ramp generator is built and sel=8 selects it.
- AD_TPL_DAC_RAMP_EN undefined: no ramp logic is built, sel=8 decodes to DDS, and dac_ramp_* are ignored.

## Structure
- Package ad_ip_jesd204_tpl_dac_pkg holds the source-select constants (SEL_DDS … SEL_PAT_RAM) and the player state enum.
- Sub-module ad_ip_jesd204_tpl_dac_pat_player contains the memory, FSM, pointer, pat_busy and pat_done. It outputs unregistered beat data.
- The top level holds the decode, fixed pattern, ramp and output register.

## Test plan
- sel=2, dma lanes 0x1234/0x5678/0x9ABC/0xDEF0, BITS_PER_SAMPLE=16 → identical dac_data one clock later, dac_enable=1.
- sel=1, pat_0=0x1111, pat_1=0x2222 → dac_data=0x2222111122221111. mask=1 → DMA data and dac_enable=1 after one clock.
- Write samples 0..15, pat_length=2, loop=0, sel=9, sync → beats {0..3}, {4..7}, then zero. pat_done pulses once with beat {4..7}; the FSM stays DONE until the next sync.
- Same memory, loop=1 → beats 0,1,0,1…. A sync mid-beat-1 makes beat 0 appear two clocks later. sel→0 → IDLE and DDS output one clock later.
- Ramp: start=0xFFFE, step=1, sync → lanes FFFE, FFFF, 0000, 0001, then 0002…0005 (wrap).
- Assert reset during PLAY → all outputs 0 at once. Release, sel=9, sync → the previously written pattern replays unchanged.
